// File: rtl/font_mem.sv
// font_mem: 16-glyph (hex 0-F) 8x8 1bpp font memory, one registered glyph row per access.
//   clk   in  1  system clock, rising edge
//   rstn  in  1  synchronous active-low reset; clears data only, never the contents
//   addr  in  7  {glyph[3:0], row[2:0]}, row 0 = top
//   data  out 8  glyph row, bit 7 = leftmost pixel, 1 = foreground, 1-cycle latency
//   FONTMEM_WRITE_EN defined: contents become a RAM preloaded with the font, adding
//   we in 1, waddr in 7, wdata in 8; reads during a write to the same word return old data.
module font_mem (
  input  logic       clk,
  input  logic       rstn,
`ifdef FONTMEM_WRITE_EN
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
`endif
  input  logic [6:0] addr,
  output logic [7:0] data
);
  // Each glyph packed top row in bits 63:56; row 7 is the blank inter-line spacer.
  function automatic logic [63:0] glyph(input logic [3:0] g);
    case (g)
      4'h0: glyph = 64'h3C666E7666663C00;
      4'h1: glyph = 64'h1838181818187E00;
      4'h2: glyph = 64'h3C66060C30607E00;
      4'h3: glyph = 64'h3C66061C06663C00;
      4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5: glyph = 64'h7E607C0606663C00;
      4'h6: glyph = 64'h3C607C6666663C00;
      4'h7: glyph = 64'h7E060C1830303000;
      4'h8: glyph = 64'h3C66663C66663C00;
      4'h9: glyph = 64'h3C66663E060C3800;
      4'hA: glyph = 64'h183C66667E666600;
      4'hB: glyph = 64'h7C66667C66667C00;
      4'hC: glyph = 64'h3C66606060663C00;
      4'hD: glyph = 64'h786C6666666C7800;
      4'hE: glyph = 64'h7E60607C60607E00;
      default: glyph = 64'h7E60607C60606000;
    endcase
  endfunction
  function automatic logic [7:0] rom(input logic [6:0] a);
    rom = 8'(glyph(a[6:3]) >> {~a[2:0], 3'b000});
  endfunction
`ifdef FONTMEM_WRITE_EN
  function automatic logic [127:0][7:0] font_init();
    for (int i = 0; i < 128; i++) font_init[i] = rom(7'(i));
  endfunction
  logic [127:0][7:0] mem = font_init();
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (we) mem[waddr] <= wdata;
      data <= mem[addr];
    end else begin
      data <= '0;
    end
  end
`else
  always_ff @(posedge clk) data <= rstn ? rom(addr) : '0;
`endif
endmodule

// File: tb/tb_font_mem.sv
// tb_font_mem: directed self-checking bench for font_mem (extra write tests under FONTMEM_WRITE_EN).
module tb_font_mem;
  logic       clk = 0;
  logic       rstn = 0;
  logic [6:0] addr = '0;
  logic [7:0] data;
  logic       we = 0;
  logic [6:0] waddr = '0;
  logic [7:0] wdata = '0;
  int         nvec = 0;
  int         nerr = 0;
  logic [63:0] gl [16] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
    64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
    64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000};
  font_mem dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef FONTMEM_WRITE_EN
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
`endif
    .addr (addr),
    .data (data)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] expect_row(input logic [6:0] a);
    logic [63:0] g;
    g = gl[a[6:3]];
    return g[63 - 8 * int'(a[2:0]) -: 8];
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] exp);
    nvec++;
    assert (data === exp) else begin
      nerr++;
      $error("FAIL %s: data=%h expected=%h", tag, data, exp);
    end
  endtask
  initial begin
    logic [6:0] a;
    rstn = 0; addr = 7'd5;
    step(); chk("reset0", 8'h00);
    step(); chk("reset1", 8'h00);
    rstn = 1;
    step(); chk("release_addr5", 8'h66);
    for (int i = 0; i < 128; i++) begin
      addr = 7'(i);
      step(); chk($sformatf("sweep_%0d", i), expect_row(7'(i)));
      if (i[2:0] == 3'd7) chk($sformatf("row7_%0d", i), 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      addr = 7'd0 + 7'(i);
      step(); chk($sformatf("glyph0_r%0d", i), expect_row(7'(i)));
    end
    for (int i = 0; i < 8; i++) begin
      addr = 7'd80 + 7'(i);
      step(); chk($sformatf("glyphA_r%0d", i), expect_row(7'd80 + 7'(i)));
    end
    a = 7'd127; addr = a;
    step(); chk("addr127", 8'h00);
    a = a + 7'd1; addr = a;
    step(); chk("wrap_to_0", 8'h3C);
    addr = 7'd8;
    step(); chk("hold8_a", 8'h18);
    step(); chk("hold8_b", 8'h18);
    rstn = 0;
    step(); chk("hold8_reset", 8'h00);
    rstn = 1;
    step(); chk("hold8_release", 8'h18);
    step(); chk("hold8_c", 8'h18);
`ifdef FONTMEM_WRITE_EN
    addr = 7'd8; we = 1; waddr = 7'd8; wdata = 8'hA5;
    step(); chk("rdw_old", 8'h18);
    we = 0;
    step(); chk("rdw_new", 8'hA5);
    rstn = 0;
    step(); chk("wr_reset", 8'h00);
    rstn = 1;
    step(); chk("wr_persist", 8'hA5);
    rstn = 0; we = 1; waddr = 7'd0; wdata = 8'hFF;
    step(); chk("wr_in_reset", 8'h00);
    rstn = 1; we = 0; addr = 7'd0;
    step(); chk("wr_in_reset_ignored", 8'h3C);
    addr = 7'd9;
    step(); chk("neighbour_intact", 8'h38);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
